decode_stage: RTL and testbench

Registered RV32I instruction-decode pipeline stage placed between fetch and execute. It decodes one instruction per cycle into register addresses, funct fields, the control bundle and a fully assembled immediate. The decoded packet is held in a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush. It is a parametrised successor of the combinational decoder and adds optional M-extension decode, all five immediate formats, and an illegal-instruction flag.

---
 rtl/decode_pkg.sv | 60 ++++++
 rtl/decode_comb.sv | 104 ++++++++++
 rtl/decode_stage.sv | 116 +++++++++++
 tb/tb_decode_stage.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
//==============================================================================
// Package : decode_pkg
// Opcodes, control words, decoded-packet type and skid state for decode_stage.
// Rev     : 1.0
//==============================================================================
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Instruction-format one-hot {R,I,S,B,U,J,Z}
    localparam logic [6:0] T_R = 7'b1000000;
    localparam logic [6:0] T_I = 7'b0100000;
    localparam logic [6:0] T_S = 7'b0010000;
    localparam logic [6:0] T_B = 7'b0001000;
    localparam logic [6:0] T_U = 7'b0000100;
    localparam logic [6:0] T_J = 7'b0000010;

    localparam logic [1:0] ALUOP_MULDIV = 2'b11;

    // {branch, jump[1:0], mem_read, mem_write, reg_write, to_reg, result_sel[1:0],
    //  alu_src, pc_add, types[6:0], alu_ctrlop[1:0], valid_inst}
    localparam logic [20:0] DEC_LUI    = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, T_U, 2'b00, 1'b1};
    localparam logic [20:0] DEC_AUIPC  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, T_U, 2'b00, 1'b1};
    localparam logic [20:0] DEC_JAL    = {1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, T_J, 2'b00, 1'b1};
    localparam logic [20:0] DEC_JALR   = {1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, T_I, 2'b00, 1'b1};
    localparam logic [20:0] DEC_BRANCH = {1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, T_B, 2'b01, 1'b1};
    localparam logic [20:0] DEC_LOAD   = {1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, T_I, 2'b00, 1'b1};
    localparam logic [20:0] DEC_STORE  = {1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, T_S, 2'b00, 1'b1};
    localparam logic [20:0] DEC_OPIMM  = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, T_I, 2'b10, 1'b1};
    localparam logic [20:0] DEC_OP     = {1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, T_R, 2'b10, 1'b1};
    localparam logic [20:0] DEC_INVALID = 21'd0;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [20:0] ctrl;
        logic [31:0] imm;
        logic        illegal;
    } decode_pkt_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/decode_comb.sv
`default_nettype none
//==============================================================================
// Module : decode_comb
// Combinational RV32I(+M) decoder: instruction word to decoded packet.
// Rev    : 1.0
//==============================================================================
module decode_comb
    import decode_pkg::*;
#(
    parameter int EN_M = 0
) (
    input  logic [31:0]  instr,
    output decode_pkt_t  pkt
);

    logic [6:0]  w_opcode;
    logic [6:0]  w_funct7;
    logic [2:0]  w_funct3;
    logic        w_f7_base;
    logic        w_f7_mul;
    logic [20:0] w_ctrl;
    logic [31:0] w_imm;
    logic        w_known;
    logic        w_bad_f7;
    logic        w_illegal;

    assign w_opcode  = instr[6:0];
    assign w_funct3  = instr[14:12];
    assign w_funct7  = instr[31:25];
    assign w_f7_base = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
    assign w_f7_mul  = (EN_M != 0) && (w_funct7 == 7'b0000001);

    always_comb begin
        w_ctrl   = DEC_INVALID;
        w_imm    = '0;
        w_known  = 1'b1;
        w_bad_f7 = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_ctrl = DEC_LUI;
                w_imm  = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_ctrl = DEC_AUIPC;
                w_imm  = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_ctrl = DEC_JAL;
                w_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_ctrl = DEC_JALR;
                w_imm  = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_BRANCH: begin
                w_ctrl = DEC_BRANCH;
                w_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LOAD: begin
                w_ctrl = DEC_LOAD;
                w_imm  = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                w_ctrl = DEC_STORE;
                w_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_OPIMM: begin
                w_ctrl = DEC_OPIMM;
                w_imm  = {{20{instr[31]}}, instr[31:20]};
                // Shift-immediates reuse funct7 as an opcode extension
                if ((w_funct3[1:0] == 2'b01) && !w_f7_base) begin
                    w_bad_f7 = 1'b1;
                end
            end
            OPC_OP: begin
                w_ctrl = DEC_OP;
                if (w_f7_mul) begin
                    w_ctrl[2:1] = ALUOP_MULDIV;
                end else if (!w_f7_base) begin
                    w_bad_f7 = 1'b1;
                end
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

    assign w_illegal = (instr[1:0] != 2'b11) || !w_known || w_bad_f7;

    always_comb begin
        pkt         = '0;
        pkt.rs1     = instr[19:15];
        pkt.rs2     = instr[24:20];
        pkt.rd      = instr[11:7];
        pkt.funct3  = w_funct3;
        pkt.funct7  = w_funct7;
        pkt.illegal = w_illegal;
        pkt.ctrl    = w_illegal ? DEC_INVALID : w_ctrl;
        pkt.imm     = w_illegal ? 32'd0 : w_imm;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
//==============================================================================
// Module : decode_stage
// Registered RV32I decode stage with a 2-entry skid buffer and flush.
// Rev    : 1.0
//==============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int EN_M   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    output logic [4:0]        rd_addr,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [20:0]       ctrl,
    output logic [31:0]       imm,
    output logic              illegal
);

    decode_pkt_t       w_dec;
    decode_pkt_t       r_head;
    decode_pkt_t       r_skid;
    logic [ADDR_W-1:0] r_head_pc;
    logic [ADDR_W-1:0] r_skid_pc;
    skid_state_e       r_state;
    logic              w_accept;
    logic              w_drain;

    decode_comb #(
        .EN_M (EN_M)
    ) u_decode_comb (
        .instr (in_instr),
        .pkt   (w_dec)
    );

    // Handshakes depend only on registered state, never on out_ready
    assign in_ready  = (r_state != SKID_TWO);
    assign out_valid = (r_state != SKID_EMPTY);
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_drain   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SKID_EMPTY;
            r_head    <= '0;
            r_skid    <= '0;
            r_head_pc <= '0;
            r_skid_pc <= '0;
        end else if (flush) begin
            r_state <= SKID_EMPTY;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_head    <= w_dec;
                        r_head_pc <= in_pc;
                        r_state   <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    case ({w_accept, w_drain})
                        2'b11: begin
                            r_head    <= w_dec;
                            r_head_pc <= in_pc;
                        end
                        2'b10: begin
                            r_skid    <= w_dec;
                            r_skid_pc <= in_pc;
                            r_state   <= SKID_TWO;
                        end
                        2'b01: begin
                            r_state <= SKID_EMPTY;
                        end
                        default: begin
                        end
                    endcase
                end
                SKID_TWO: begin
                    if (w_drain) begin
                        r_head    <= r_skid;
                        r_head_pc <= r_skid_pc;
                        r_state   <= SKID_ONE;
                    end
                end
                default: begin
                    r_state <= SKID_EMPTY;
                end
            endcase
        end
    end

    assign out_pc   = r_head_pc;
    assign rs1_addr = r_head.rs1;
    assign rs2_addr = r_head.rs2;
    assign rd_addr  = r_head.rd;
    assign funct3   = r_head.funct3;
    assign funct7   = r_head.funct7;
    assign ctrl     = r_head.ctrl;
    assign imm      = r_head.imm;
    assign illegal  = r_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
//==============================================================================
// Module : tb_decode_stage
// Scoreboard bench for decode_stage (EN_M=0 and EN_M=1 instances in lockstep).
// Rev    : 1.0
//==============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] ctrl;

    logic        in_ready_m, out_valid_m, illegal_m;
    logic [31:0] out_pc_m, imm_m;
    logic [4:0]  rs1_m, rs2_m, rd_m;
    logic [2:0]  funct3_m;
    logic [6:0]  funct7_m;
    logic [20:0] ctrl_m;

    always #5 clk = ~clk;

    decode_stage #(.ADDR_W(32), .EN_M(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .funct3(funct3), .funct7(funct7), .ctrl(ctrl), .imm(imm), .illegal(illegal)
    );

    decode_stage #(.ADDR_W(32), .EN_M(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_pc(out_pc_m), .rs1_addr(rs1_m), .rs2_addr(rs2_m), .rd_addr(rd_m),
        .funct3(funct3_m), .funct7(funct7_m), .ctrl(ctrl_m), .imm(imm_m), .illegal(illegal_m)
    );

    logic [63:0] q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          prev_flush = 1'b0;
    bit          last_acc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Control word assembled from named fields; types given as bit index (6=R .. 0=Z)
    function automatic logic [20:0] mk(int br, int jmp, int mr, int mw, int rw, int tr,
                                       int rs, int as, int pa, int ty, int aop);
        logic [6:0] t;
        t = 7'(1 << ty);
        return {1'(br), 2'(jmp), 1'(mr), 1'(mw), 1'(rw), 1'(tr), 2'(rs), 1'(as), 1'(pa), t, 2'(aop), 1'b1};
    endfunction

    function automatic void model(input logic [31:0] ins, input bit en_m,
                                  output logic [20:0] c, output logic [31:0] im, output bit ill);
        int sg;
        sg  = ins[31] ? -1 : 0;
        ill = 1'b0;
        c   = '0;
        im  = '0;
        case (ins[6:0])
            7'b0110111: begin c = mk(0,0,0,0,1,0,2,0,0,2,0); im = ins & 32'hFFFFF000; end
            7'b0010111: begin c = mk(0,0,0,0,1,0,1,1,1,2,0); im = ins & 32'hFFFFF000; end
            7'b1101111: begin
                c  = mk(0,1,0,0,1,0,3,0,1,1,0);
                im = sg * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            7'b1100111: begin c = mk(0,2,0,0,1,0,3,1,0,5,0); im = sg * 2048 + int'(ins[30:20]); end
            7'b1100011: begin
                c  = mk(1,0,0,0,0,0,0,0,1,3,1);
                im = sg * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'b0000011: begin c = mk(0,0,1,0,1,1,1,1,0,5,0); im = sg * 2048 + int'(ins[30:20]); end
            7'b0100011: begin
                c  = mk(0,0,0,1,0,0,0,1,0,4,0);
                im = sg * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
            end
            7'b0010011: begin
                c  = mk(0,0,0,0,1,0,1,1,0,5,2);
                im = sg * 2048 + int'(ins[30:20]);
                if ((ins[14:12] == 3'b001 || ins[14:12] == 3'b101) &&
                    !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20)) ill = 1'b1;
            end
            7'b0110011: begin
                if (en_m && ins[31:25] == 7'h01)                        c = mk(0,0,0,0,1,0,1,0,0,6,3);
                else if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20)    c = mk(0,0,0,0,1,0,1,0,0,6,2);
                else                                                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (ins[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            c  = '0;
            im = '0;
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [9];
        int          k;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
        w = $urandom;
        k = $urandom_range(0, 13);
        if (k < 9) begin
            w[6:0] = ops[k];
        end else if (k == 9) begin
            w[6:0] = 7'b0110011; w[31:25] = 7'h01;
        end else if (k == 10) begin
            w[6:0] = 7'b0110011; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        end else if (k == 11) begin
            w[6:0] = 7'b0010011; w[13:12] = 2'b01;
            if ($urandom_range(0, 2) == 0) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    // One cycle of stimulus; the expected packet is queued at the moment of acceptance
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit rdy, input bit fl);
        @(posedge clk);
        #1;
        if (prev_flush) q.delete();
        prev_flush = fl;
        in_valid   = v;
        in_instr   = ins;
        in_pc      = pc;
        out_ready  = rdy;
        flush      = fl;
        last_acc   = v && in_ready && !fl;
        if (last_acc) q.push_back({pc, ins});
    endtask

    task automatic check_packet(input logic [63:0] e);
        logic [31:0] ins;
        logic [20:0] c;
        logic [31:0] im;
        bit          ill;
        ins = e[31:0];
        chk("pc", out_pc, e[63:32]);
        chk("fields", {2'b0, rs1_addr, rs2_addr, rd_addr, funct3, funct7},
            {2'b0, 5'(ins >> 15), 5'(ins >> 20), 5'(ins >> 7), 3'(ins >> 12), 7'(ins >> 25)});
        model(ins, 1'b0, c, im, ill);
        chk("ctrl", 32'(ctrl), 32'(c));
        chk("imm", imm, im);
        chk("illegal", 32'(illegal), 32'(ill));
        model(ins, 1'b1, c, im, ill);
        chk("ctrl_m", 32'(ctrl_m), 32'(c));
        chk("imm_m", imm_m, im);
        chk("illegal_m", 32'(illegal_m), 32'(ill));
        chk("pc_m", out_pc_m, e[63:32]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid_m !== out_valid) begin
                    n_cmp++; n_bad++;
                    $display("FAIL valid_lockstep: got %b, expected %b", out_valid_m, out_valid);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_packet: got pc %h, expected no packet", out_pc);
                    end else begin
                        check_packet(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] pc;
        bit          got;
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_ctrl", 32'(ctrl), 0);
        chk("rst_imm", imm, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_fields", {rs1_addr, rs2_addr, rd_addr, funct3, funct7, illegal}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 32'h00500093, 32'h100, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_rd", 32'(rd_addr), 1);
        chk("addi_rs1", 32'(rs1_addr), 0);
        chk("addi_imm", imm, 5);
        chk("addi_illegal", 32'(illegal), 0);

        step(1, 32'hFE000EE3, 32'h104, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_branch", 32'(ctrl[20]), 1);
        chk("beq_types", 32'(ctrl[9:3]), 32'b0001000);

        step(1, 32'h02208033, 32'h108, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("mul_illegal", 32'(illegal), 1);
        chk("mul_ctrl", 32'(ctrl), 0);
        chk("mul_m_illegal", 32'(illegal_m), 0);
        chk("mul_m_aluop", 32'(ctrl_m[2:1]), 3);

        // Backpressure: third instruction held until the buffer frees up
        step(1, 32'h00100113, 32'h200, 0, 0);
        step(1, 32'h00208193, 32'h204, 0, 0);
        step(1, 32'h40208233, 32'h208, 0, 0);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            step(1, 32'h40208233, 32'h208, 1, 0);
            got = last_acc;
        end
        chk("bp_third_accepted", 32'(got), 1);
        repeat (3) step(0, 0, 0, 1, 0);

        // Flush while full, with an instruction offered in the flush cycle
        step(1, 32'h00100113, 32'h300, 0, 0);
        step(1, 32'h00208193, 32'h304, 0, 0);
        step(1, 32'h00700293, 32'h308, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("flush_out_valid", 32'(out_valid), 0);
        chk("flush_in_ready", 32'(in_ready), 1);
        step(1, 32'h00900313, 32'h400, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("flush_drop_empty", 32'(out_valid), 0);
        repeat (2) step(0, 0, 0, 1, 0);

        // Asynchronous reset while one packet is held
        step(1, 32'h00500093, 32'h500, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("arst_pre_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_imm", imm, 0);
        chk("arst_pc", out_pc, 0);
        chk("arst_ctrl_rd", {11'b0, ctrl}, {11'b0, 21'd0});
        chk("arst_rd", 32'(rd_addr), 0);
        q.delete();
        prev_flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        pc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), pc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            if (last_acc) pc = pc + 4;
        end
        repeat (6) step(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
